// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT
// controller. The instruction ROM sits outside and answers imem_addr combinationally.
module fetch_stage #(
  parameter int N       = 64,
  parameter int IMEM_AW = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               redirect_E,
  input  logic [N-1:0]       target_E,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  output logic [31:0]        instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D,
  output logic               halted,
  output logic [15:0]        fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t       state, state_n;
  logic [N-1:0] pc;
  logic         halt_word;

  // An all-zero instruction word is the halt marker.
  assign halt_word = (imem_q == 32'h0000_0000);
  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (redirect_E)
      state_n = RUN;
    else if (state == RUN && !stall_F && halt_word)
      state_n = HALT;
  end

  always_comb begin
    halted = (state == HALT);
  end

  // Redirect outranks everything except reset, including stall and HALT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      instr_D   <= '0;
      pc_D      <= '0;
      valid_D   <= 1'b0;
      fetch_cnt <= '0;
    end else if (redirect_E) begin
      pc      <= {target_E[N-1:2], 2'b00};
      instr_D <= '0;
      pc_D    <= '0;
      valid_D <= 1'b0;
    end else if (state == HALT) begin
      instr_D <= '0;
      pc_D    <= '0;
      valid_D <= 1'b0;
    end else if (stall_F) begin
      pc <= pc;
    end else if (halt_word) begin
      instr_D <= '0;
      pc_D    <= '0;
      valid_D <= 1'b0;
    end else begin
      pc      <= pc + N'(4);
      instr_D <= imem_q;
      pc_D    <= pc;
      valid_D <= 1'b1;
      if (fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed self-checking bench for fetch_stage, using a
// rule-level reference model and a behavioural instruction ROM.
module tb_fetch_stage;

  localparam int N  = 64;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall_F = 1'b0;
  logic          redirect_E = 1'b0;
  logic [N-1:0]  target_E = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;
  logic          valid_D;
  logic          halted;
  logic [15:0]   fetch_cnt;

  logic [31:0] rom [128];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_pc, m_pcD;
  logic [31:0]  m_instr;
  logic         m_valid, m_halt;
  int           m_cnt;

  fetch_stage #(.N(N), .IMEM_AW(AW)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .redirect_E(redirect_E),
    .target_E(target_E), .imem_addr(imem_addr), .imem_q(imem_q),
    .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".instr_D"},   64'(instr_D),   64'(m_instr));
    checkOutput({tag, ".pc_D"},      pc_D,           m_pcD);
    checkOutput({tag, ".valid_D"},   64'(valid_D),   64'(m_valid));
    checkOutput({tag, ".halted"},    64'(halted),    64'(m_halt));
    checkOutput({tag, ".imem_addr"}, 64'(imem_addr), 64'((m_pc / 4) % 128));
    checkOutput({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(m_cnt));
  endtask

  task automatic modelBubble();
    m_instr = '0;
    m_pcD   = '0;
    m_valid = 1'b0;
  endtask

  // One clock edge of the reference rules, evaluated on pre-edge state.
  task automatic modelEdge(input logic rst, input logic st, input logic rd, input logic [N-1:0] tgt);
    logic [31:0] w;
    if (!rst) begin
      m_pc = '0; m_halt = 1'b0; m_cnt = 0;
      modelBubble();
    end else if (rd) begin
      m_pc = (tgt / 4) * 4;
      m_halt = 1'b0;
      modelBubble();
    end else if (m_halt) begin
      modelBubble();
    end else if (!st) begin
      w = rom[(m_pc / 4) % 128];
      if (w == 32'h0) begin
        m_halt = 1'b1;
        modelBubble();
      end else begin
        m_instr = w;
        m_pcD   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic st,
                               input logic rd, input logic [N-1:0] tgt, input bit chk);
    reset = rst; stall_F = st; redirect_E = rd; target_E = tgt;
    modelEdge(rst, st, rd, tgt);
    @(posedge clk);
    #1;
    if (chk) compareModel(tag);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom[i] = $urandom;
      if (rom[i] == 32'h0) rom[i] = 32'h13;
    end
    rom[0]  = 32'hf800_0001;
    rom[55] = 32'h0;
    m_pc = '0; m_pcD = '0; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;

    // Reset with noisy control inputs
    #1;
    applyStimulus("rst0", 1'b0, 1'b1, 1'b1, 64'h40, 1);
    applyStimulus("rst1", 1'b0, 1'b0, 1'b1, 64'h80, 1);
    checkOutput("rst.valid_D", 64'(valid_D), 64'h0);
    checkOutput("rst.imem_addr", 64'(imem_addr), 64'h0);

    applyStimulus("first", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("first.instr_D", 64'(instr_D), 64'hf800_0001);
    checkOutput("first.imem_addr", 64'(imem_addr), 64'h1);
    checkOutput("first.fetch_cnt", 64'(fetch_cnt), 64'h1);

    applyStimulus("pc8", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b1, 1'b1, 1'b0, 64'h0, 1);
      checkOutput("stall.pc_D", pc_D, 64'h4);
      checkOutput("stall.imem_addr", 64'(imem_addr), 64'h2);
      checkOutput("stall.fetch_cnt", 64'(fetch_cnt), 64'h2);
    end
    applyStimulus("resume", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("resume.pc_D", pc_D, 64'h8);

    // Redirect wins over stall; target low bits are dropped
    applyStimulus("redir16", 1'b1, 1'b1, 1'b1, 64'h16, 1);
    checkOutput("redir16.imem_addr", 64'(imem_addr), 64'h5);
    applyStimulus("redir16b", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("redir16b.instr_D", 64'(instr_D), 64'(rom[5]));
    checkOutput("redir16b.pc_D", pc_D, 64'h14);

    // Redirect in the same cycle as the halt word keeps RUN
    applyStimulus("toDC", 1'b1, 1'b0, 1'b1, 64'hDC, 1);
    applyStimulus("racehalt", 1'b1, 1'b0, 1'b1, 64'h20, 1);
    checkOutput("racehalt.halted", 64'(halted), 64'h0);
    checkOutput("racehalt.imem_addr", 64'(imem_addr), 64'h8);

    // Halt entry, hold and exit
    applyStimulus("toDC2", 1'b1, 1'b0, 1'b1, 64'hDC, 1);
    applyStimulus("halt", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("halt.halted", 64'(halted), 64'h1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("hold", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 64'h0, 1);
      checkOutput("hold.imem_addr", 64'(imem_addr), 64'd55);
    end
    applyStimulus("unhalt", 1'b1, 1'b0, 1'b1, 64'hA0, 1);
    checkOutput("unhalt.halted", 64'(halted), 64'h0);
    checkOutput("unhalt.imem_addr", 64'(imem_addr), 64'd40);
    applyStimulus("unhalt2", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("unhalt2.instr_D", 64'(instr_D), 64'(rom[40]));

    // Word-address wrap
    applyStimulus("to1FC", 1'b1, 1'b0, 1'b1, 64'h1FC, 1);
    applyStimulus("wrap1", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("wrap1.pc_D", pc_D, 64'h1FC);
    checkOutput("wrap1.imem_addr", 64'(imem_addr), 64'h0);
    applyStimulus("wrap2", 1'b1, 1'b0, 1'b0, 64'h0, 1);
    checkOutput("wrap2.pc_D", pc_D, 64'h200);

    // Mid-run reset beats stall and redirect
    applyStimulus("midrst", 1'b0, 1'b1, 1'b1, 64'h44, 1);
    checkOutput("midrst.fetch_cnt", 64'(fetch_cnt), 64'h0);
    checkOutput("midrst.pc_D", pc_D, 64'h0);

    // Random traffic, with occasional halt words in the ROM
    for (int i = 0; i < 128; i++)
      if ($urandom_range(0, 15) == 0) rom[i] = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] t;
      t = {32'($urandom), 32'($urandom)};
      applyStimulus("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), t, 1);
    end

    // Counter saturation
    for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 | 32'(i);
    applyStimulus("satrst", 1'b0, 1'b0, 1'b0, 64'h0, 1);
    for (int i = 0; i < 65534; i++)
      applyStimulus("satrun", 1'b1, 1'b0, 1'b0, 64'h0, 0);
    compareModel("satFFFE");
    checkOutput("satFFFE.fetch_cnt", 64'(fetch_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sat", 1'b1, 1'b0, 1'b0, 64'h0, 1);
      checkOutput("sat.fetch_cnt", 64'(fetch_cnt), 64'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 64: program counter and target width in bits.
REQ-002 Parameter IMEM_AW, default 7: instruction-memory word-address width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 stall_F  input  1  1 = hold the PC and the IF/ID register.
REQ-006 redirect_E  input  1  1 = taken branch from a later stage; load target_E.
REQ-007 target_E  input  N  byte address of the redirect target.
REQ-008 imem_addr  output  IMEM_AW  word address to the instruction ROM.
REQ-009 imem_q  input  32  instruction word returned combinationally for imem_addr.
REQ-010 instr_D  output  32  IF/ID instruction.
REQ-011 pc_D  output  N  IF/ID byte address of instr_D.
REQ-012 valid_D  output  1  1 = instr_D/pc_D hold a real fetch; 0 = bubble.
REQ-013 halted  output  1  1 = FSM in HALT.
REQ-014 fetch_cnt  output  16  count of valid IF/ID loads, saturating.

Function
REQ-015 imem_addr SHALL be combinational: PC[IMEM_AW+1:2]; it wraps mod 2^IMEM_AW words with no error.
REQ-016 FSM states SHALL be RUN and HALT only.
REQ-017 Priority per edge SHALL be: reset > redirect_E > HALT hold > stall_F > normal fetch.
REQ-018 Normal fetch (RUN, no stall, no redirect, imem_q != 0): PC <= PC+4 mod 2^N; IF/ID <= {imem_q, PC, valid 1}; fetch_cnt += 1.
REQ-019 Stall (RUN, stall_F=1, no redirect): PC, IF/ID, fetch_cnt and state SHALL hold.
REQ-020 Redirect (redirect_E=1, any state, stall_F ignored): PC <= {target_E[N-1:2], 2'b00}; IF/ID <= bubble; state <= RUN; fetch_cnt holds.
REQ-021 Bubble SHALL be instr_D=0, pc_D=0, valid_D=0.
REQ-022 Halt entry (RUN, no stall, no redirect, imem_q == 32'h00000000): state <= HALT; PC holds; IF/ID <= bubble; fetch_cnt holds.
REQ-023 In HALT without redirect: PC holds; IF/ID stays bubble; stall_F is ignored.
REQ-024 halted SHALL equal 1 exactly while the state is HALT.
REQ-025 fetch_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-026 Latency: a word presented at imem_addr appears on instr_D one edge later; a redirect produces exactly one bubble before the target instruction appears.
REQ-027 Redirect and halt-condition in the same cycle: redirect wins; state is RUN.

Reset
REQ-028 While reset=0 at an edge: PC=0, state=RUN, instr_D=0, pc_D=0, valid_D=0, halted=0, fetch_cnt=0, regardless of stall_F or redirect_E.
REQ-029 After reset the first edge with reset=1 SHALL fetch from address 0 (imem_addr=0 throughout reset).
REQ-030 Reset asserted mid-operation SHALL discard in-flight IF/ID contents and HALT state on that edge.

Verification
REQ-031 ROM[0]=32'hf8000001, reset=0 for 2 edges, then released -> first edge: instr_D=32'hf8000001, pc_D=0, valid_D=1, imem_addr=1, fetch_cnt=1.
REQ-032 Run to PC=8, stall_F=1 for 3 edges -> instr_D/pc_D=4/valid_D and imem_addr=2 unchanged for all 3 edges; fetch_cnt constant; normal advance resumes on release.
REQ-033 stall_F=1 and redirect_E=1 with target_E=64'h16 -> next edge: valid_D=0, imem_addr=5 (low bits cleared); following edge: instr_D=ROM[5], pc_D=64'h14, valid_D=1.
REQ-034 ROM[55]=0 fetched at PC=64'hDC -> next edge: halted=1, valid_D=0, imem_addr=55 held for 10 edges; redirect_E=1, target_E=64'hA0 -> halted=0, imem_addr=40, then instr_D=ROM[40].
REQ-035 target_E=64'h1FC, then free-run -> imem_addr 127 then 0; pc_D 64'h1FC then 64'h200.
REQ-036 Mid-run reset=0 with stall_F=1 and redirect_E=1 -> next edge all outputs zero, halted=0; pre-loading fetch_cnt to 16'hFFFE and fetching 3 words -> fetch_cnt=16'hFFFF.
